fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 Parameter TAPS, default 49, number of FIR coefficients written per load.
REQ-002 Parameter COEFF_WIDTH, default 16, signed coefficient width.
REQ-003 Parameter ADDR_WIDTH, default 6, coefficient address width; SHALL satisfy 2^ADDR_WIDTH >= TAPS.
REQ-004 Parameter TIMEOUT, default 255, maximum idle cycles allowed between accepted coefficients during a load.
REQ-005 Parameter SETTLE_CYCLES, default 2, cycles fir_en is held low after the last write.
REQ-006 Port clk, input, 1, the block's only clock.
REQ-007 Port rst, input, 1, asynchronous reset, active-high.
REQ-008 Port load_req, input, 1, single-cycle request to start a coefficient reload.
REQ-009 Port s_valid, input, 1, coefficient stream valid.
REQ-010 Port s_data, input, COEFF_WIDTH, signed coefficient stream data, presented in address order starting at 0.
REQ-011 Port s_ready, output, 1, coefficient stream ready.
REQ-012 Port wr_addr, output, ADDR_WIDTH, coefficient write address to the FIR filter.
REQ-013 Port wr_data, output, COEFF_WIDTH, coefficient write data to the FIR filter.
REQ-014 Port wr_en, output, 1, coefficient write strobe to the FIR filter.
REQ-015 Port fir_en, output, 1, FIR filter run enable.
REQ-016 Port busy, output, 1, high in LOAD and SETTLE.
REQ-017 Port done, output, 1, single-cycle pulse when a load completes.
REQ-018 Port err, output, 1, sticky load-timeout flag.

Function
REQ-019 States SHALL be IDLE, LOAD, SETTLE, RUN and ERROR.
- IDLE is entered after reset.
- In IDLE, fir_en=0.
REQ-020 load_req in IDLE, RUN or ERROR SHALL cause the following on the next cycle:
- go to LOAD;
- fir_en=0;
- address counter=0;
- timeout counter=0;
- err=0.
REQ-021 load_req while in LOAD or SETTLE SHALL be ignored.
REQ-022 In LOAD, s_ready SHALL be 1; s_ready SHALL be 0 in every other state.
REQ-023 A transfer occurs when s_valid and s_ready are both high. Each transfer SHALL register the following on the next edge:
- wr_en=1;
- wr_addr=current count;
- wr_data=s_data.
The count then increments. Write latency is 1 cycle.
REQ-024 wr_en SHALL be 0 on every cycle that does not follow a transfer.
REQ-025 wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-026 The transfer with count=TAPS-1 SHALL move the block from LOAD to SETTLE.
REQ-027 The SETTLE cycle counter SHALL start on the cycle the final wr_en is asserted.
REQ-028 In LOAD, the timeout counter SHALL reset on each transfer and increment on every cycle without a transfer.
REQ-029 When the timeout counter reaches TIMEOUT, the block SHALL go to ERROR and set err=1.
- No further writes are issued.
- fir_en stays 0.
REQ-030 SETTLE SHALL last exactly SETTLE_CYCLES cycles. The block then enters RUN with fir_en=1, and done pulses for one cycle on the first RUN cycle.
REQ-031 In RUN, fir_en SHALL remain 1 until load_req is received.
REQ-032 ERROR SHALL persist, with err=1 and fir_en=0, until load_req is received.
REQ-033 Counter widths SHALL be sized so that the address and timeout counters never wrap before their terminal compare.

Reset
REQ-034 Asserting rst SHALL immediately force the following, without waiting for a clock edge:
- state=IDLE;
- s_ready=0, wr_en=0, fir_en=0, busy=0, done=0, err=0;
- wr_addr=0, wr_data=0;
- all counters=0.
REQ-035 rst asserted mid-LOAD SHALL abandon the partial load. After release, the block SHALL stay in IDLE, not writing, until load_req is received.

Structure
REQ-036 The state enumeration and default parameter constants (TAPS, COEFF_WIDTH, ADDR_WIDTH) SHALL reside in the shared package fir_pkg.
REQ-037 The block SHALL be a single module with no sub-modules. The FSM, address counter, timeout counter and settle counter are all internal.

Verification
REQ-038 Scenario: load_req, then 49 back-to-back valid words with values equal to address-36.
- 49 wr_en pulses, addresses 0..48, 1-cycle latency.
- fir_en rises 2 cycles after the last wr_en.
- done pulses once.
REQ-039 Scenario: s_valid toggled 1/0 every cycle during load.
- 49 writes, in order, with no duplicates.
- s_ready low outside LOAD.
REQ-040 Scenario: stall s_valid for 255 cycles after word 10.
- ERROR with err=1.
- fir_en=0.
- Exactly 10 writes issued.
- A subsequent load_req clears err.
REQ-041 Scenario: load_req pulsed during LOAD at word 20, and again during SETTLE.
- Both pulses ignored.
- Address sequence continues unbroken.
REQ-042 Scenario: rst pulsed at word 30.
- All outputs 0 immediately.
- No writes after release until a new load_req.
REQ-043 Scenario: load_req while in RUN.
- fir_en drops on the next cycle.
- A full reload completes and done pulses once.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR coefficient-loader definitions: default sizing constants and FSM state encoding.
package fir_pkg;

    localparam int DEF_TAPS        = 49;
    localparam int DEF_COEFF_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_ERROR
    } fir_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams TAPS coefficients into a FIR filter, holds it disabled while settling, then enables it.
// Latency: one cycle from accepted stream word to wr_en; fir_en rises SETTLE_CYCLES after the last write.
// Backpressure: s_ready is high only in LOAD; a load stalled TIMEOUT cycles aborts to ERROR.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int TAPS          = DEF_TAPS,
    parameter int COEFF_WIDTH   = DEF_COEFF_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int TIMEOUT       = 255,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_req,
    input  logic                          s_valid,
    input  logic signed [COEFF_WIDTH-1:0] s_data,
    output logic                          s_ready,
    output logic        [ADDR_WIDTH-1:0]  wr_addr,
    output logic signed [COEFF_WIDTH-1:0] wr_data,
    output logic                          wr_en,
    output logic                          fir_en,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TAPS - 1);
    localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [SET_W-1:0]      SET_LAST  = SET_W'(SETTLE_CYCLES - 1);

    fir_state_t                   state_q,    state_d;
    logic        [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic        [TMO_W-1:0]      tmo_cnt_q,  tmo_cnt_d;
    logic        [SET_W-1:0]      set_cnt_q,  set_cnt_d;
    logic                         wr_en_q,    wr_en_d;
    logic        [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic signed [COEFF_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                         done_q,     done_d;
    logic        [TMO_W-1:0]      tmo_inc;

    assign tmo_inc = tmo_cnt_q + TMO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            set_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            set_cnt_q  <= set_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        set_cnt_d  = set_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (load_req) begin
                    state_d    = ST_LOAD;
                    addr_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_cnt_q;
                    wr_data_d = s_data;
                    tmo_cnt_d = '0;
                    if (addr_cnt_q == LAST_ADDR) begin
                        // Settle count begins on the cycle the final wr_en is visible.
                        state_d   = ST_SETTLE;
                        set_cnt_d = '0;
                    end else begin
                        addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode the state register directly so reset clears them without a clock.
    assign s_ready = (state_q == ST_LOAD);
    assign busy    = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign fir_en  = (state_q == ST_RUN);
    assign err     = (state_q == ST_ERROR);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scenario bench for fir_coeff_loader: queued expected writes are matched against every wr_en.
module tb_fir_coeff_loader;

    localparam int TAPS          = 49;
    localparam int COEFF_WIDTH   = 16;
    localparam int ADDR_WIDTH    = 6;
    localparam int TIMEOUT       = 255;
    localparam int SETTLE_CYCLES = 2;
    localparam int WR_W          = ADDR_WIDTH + COEFF_WIDTH;

    logic                          clk;
    logic                          rst;
    logic                          load_req;
    logic                          s_valid;
    logic signed [COEFF_WIDTH-1:0] s_data;
    logic                          s_ready;
    logic        [ADDR_WIDTH-1:0]  wr_addr;
    logic signed [COEFF_WIDTH-1:0] wr_data;
    logic                          wr_en;
    logic                          fir_en;
    logic                          busy;
    logic                          done;
    logic                          err;

    int checks = 0;
    int errors = 0;

    logic [WR_W-1:0] sb_q[$];
    int send_idx     = 0;
    int cyc          = 0;
    int wr_cnt       = 0;
    int done_cnt     = 0;
    int last_wr_cyc  = 0;
    int fir_rise_cyc = 0;
    int done_cyc     = 0;
    bit fir_en_prev  = 1'b0;

    fir_coeff_loader #(
        .TAPS(TAPS), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .TIMEOUT(TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .fir_en(fir_en), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, got=running want=finished");
        $fatal(1);
    end

    always @(negedge clk) begin
        logic [WR_W-1:0] exp_w;
        cyc++;
        if (fir_en && !fir_en_prev) fir_rise_cyc = cyc;
        fir_en_prev = fir_en;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr=%0d data=%0d want no write", wr_addr, wr_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    errors++;
                    $display("FAIL wr_match got addr=%0d data=%0d want addr=%0d data=%0d",
                             wr_addr, wr_data, exp_w[WR_W-1:COEFF_WIDTH],
                             $signed(exp_w[COEFF_WIDTH-1:0]));
                end
            end
        end
    end

    task automatic start_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        send_idx = 0;
    endtask

    // Offers words addr-36 in order; each accepted word is queued as an expected write.
    task automatic stream(input int n, input bit toggle, input int req_at);
        int sent  = 0;
        int guard = 0;
        bit ph    = 1'b1;
        while (sent < n && guard < 1000) begin
            @(negedge clk);
            s_valid  = toggle ? ph : 1'b1;
            ph       = ~ph;
            s_data   = COEFF_WIDTH'(send_idx - 36);
            load_req = (req_at == send_idx) && s_valid;
            if (s_valid && s_ready) begin
                sb_q.push_back({ADDR_WIDTH'(send_idx), s_data});
                send_idx++;
                sent++;
            end
            guard++;
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fir_en) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; s_valid = 1'b0; s_data = '0;
        #1;
        checks++;
        if ({s_ready, wr_en, fir_en, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {s_ready, wr_en, fir_en, busy, done, err});
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_wr_bus got addr=%0d data=%0d want 0 0", wr_addr, wr_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0 || fir_en !== 1'b0 || busy !== 1'b0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL idle_after_reset got ready=%b fir_en=%b busy=%b writes=%0d want 0 0 0 0",
                     s_ready, fir_en, busy, wr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d0, w0;
        bit ok;
        logic signed [COEFF_WIDTH-1:0] last_d;
        last_d = COEFF_WIDTH'(TAPS - 1 - 36);
        start_load();
        d0 = done_cnt; w0 = wr_cnt;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || fir_en !== 1'b0) begin
            errors++;
            $display("FAIL load_entry got ready=%b busy=%b fir_en=%b want 1 1 0", s_ready, busy, fir_en);
        end
        stream(TAPS, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || fir_en !== 1'b0) begin
            errors++;
            $display("FAIL settle_state got busy=%b ready=%b fir_en=%b want 1 0 0", busy, s_ready, fir_en);
        end
        wait_run(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_run got fir_en=0 want 1 within 20 cycles"); end
        checks++;
        if (wr_cnt - w0 != TAPS) begin
            errors++; $display("FAIL b2b_write_count got=%0d want=%0d", wr_cnt - w0, TAPS);
        end
        checks++;
        if (fir_rise_cyc - last_wr_cyc != SETTLE_CYCLES) begin
            errors++;
            $display("FAIL b2b_settle_gap got=%0d want=%0d", fir_rise_cyc - last_wr_cyc, SETTLE_CYCLES);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != fir_rise_cyc) begin
            errors++;
            $display("FAIL b2b_done got pulses=%0d at=%0d want 1 at=%0d", done_cnt - d0, done_cyc, fir_rise_cyc);
        end
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== ADDR_WIDTH'(TAPS - 1) || wr_data !== last_d) begin
            errors++;
            $display("FAIL b2b_hold got en=%b addr=%0d data=%0d want 0 %0d %0d",
                     wr_en, wr_addr, wr_data, TAPS - 1, last_d);
        end
        checks++;
        if (fir_en !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_run_flags got fir_en=%b busy=%b err=%b ready=%b want 1 0 0 0",
                     fir_en, busy, err, s_ready);
        end
    endtask

    task automatic test_reload_from_run();
        int d0, w0;
        bit ok;
        @(negedge clk);
        load_req = 1'b1;
        checks++;
        if (fir_en !== 1'b1) begin errors++; $display("FAIL run_before_req got fir_en=%b want 1", fir_en); end
        @(negedge clk);
        load_req = 1'b0;
        send_idx = 0;
        d0 = done_cnt; w0 = wr_cnt;
        checks++;
        if (fir_en !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_reload_entry got fir_en=%b ready=%b busy=%b want 0 1 1", fir_en, s_ready, busy);
        end
        stream(TAPS, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        wait_run(ok);
        checks++;
        if (!ok || wr_cnt - w0 != TAPS || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL run_reload got run=%b writes=%0d done=%0d want 1 %0d 1", ok, wr_cnt - w0, done_cnt - d0, TAPS);
        end
    endtask

    task automatic test_toggle();
        int d0, w0;
        bit ok;
        start_load();
        d0 = done_cnt; w0 = wr_cnt;
        stream(TAPS, 1'b1, -1);
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL toggle_ready_settle got=%b want 0", s_ready); end
        wait_run(ok);
        checks++;
        if (!ok || wr_cnt - w0 != TAPS || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL toggle_load got run=%b writes=%0d done=%0d want 1 %0d 1", ok, wr_cnt - w0, done_cnt - d0, TAPS);
        end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL toggle_ready_run got=%b want 0", s_ready); end
    endtask

    task automatic test_load_req_ignored();
        int d0, w0;
        bit ok;
        start_load();
        d0 = done_cnt; w0 = wr_cnt;
        stream(TAPS, 1'b0, 20);
        @(negedge clk);
        s_valid  = 1'b0;
        load_req = 1'b1;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL ignore_in_settle got busy=%b ready=%b want 1 0", busy, s_ready);
        end
        @(negedge clk);
        load_req = 1'b0;
        wait_run(ok);
        checks++;
        if (!ok || wr_cnt - w0 != TAPS || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ignore_load got run=%b writes=%0d done=%0d want 1 %0d 1", ok, wr_cnt - w0, done_cnt - d0, TAPS);
        end
    endtask

    task automatic test_timeout();
        int w0, d0;
        bit ok;
        start_load();
        w0 = wr_cnt;
        stream(10, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_early got ready=%b err=%b want 1 0", s_ready, err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || fir_en !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error got err=%b fir_en=%b ready=%b busy=%b want 1 0 0 0", err, fir_en, s_ready, busy);
        end
        s_valid = 1'b1;
        repeat (8) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || fir_en !== 1'b0 || wr_cnt - w0 != 10) begin
            errors++;
            $display("FAIL timeout_sticky got err=%b fir_en=%b writes=%0d want 1 0 10", err, fir_en, wr_cnt - w0);
        end
        start_load();
        checks++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_clear got err=%b ready=%b want 0 1", err, s_ready);
        end
        d0 = done_cnt; w0 = wr_cnt;
        stream(TAPS, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        wait_run(ok);
        checks++;
        if (!ok || wr_cnt - w0 != TAPS || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL timeout_recover got run=%b writes=%0d done=%0d want 1 %0d 1", ok, wr_cnt - w0, done_cnt - d0, TAPS);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0, w1;
        start_load();
        w0 = wr_cnt;
        stream(30, 1'b0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, wr_en, fir_en, busy, done, err} !== 6'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got flags=%b addr=%0d data=%0d want 000000 0 0",
                     {s_ready, wr_en, fir_en, busy, done, err}, wr_addr, wr_data);
        end
        checks++;
        if (wr_cnt - w0 != 30 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_writes got=%0d pending=%0d want 30 0", wr_cnt - w0, sb_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        w1 = wr_cnt;
        s_valid = 1'b1;
        repeat (20) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (wr_cnt != w1 || s_ready !== 1'b0 || busy !== 1'b0 || fir_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle got writes=%0d ready=%b busy=%b fir_en=%b want 0 0 0 0",
                     wr_cnt - w1, s_ready, busy, fir_en);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_reload_from_run();
        test_toggle();
        test_load_req_ignored();
        test_timeout();
        test_reset_mid_load();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got pending=%0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
